div_sqrt_seq: RTL and testbench

- Front-end sequencer and result packer for the iterative non-restoring divide/square-root core.
- Accepts packed single-precision operands through a valid/ready handshake and unpacks them.
- Special cases are resolved locally. All other operations start the core, wait for Core_done_SI, then normalize, range-check and pack the result with exception flags.
- It is the initiator of the core's Start/Done protocol and the consumer of the core's pre-normalized mantissa and exponent.

---
 rtl/div_sqrt_seq_pkg.sv | 53 +++++
 rtl/div_sqrt_seq_special.sv | 77 +++++++
 rtl/div_sqrt_seq.sv | 210 +++++++++++++++++++++
 tb/tb_div_sqrt_seq.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sqrt_seq_pkg.sv
// ----------------------------------------------------------------------------
// div_sqrt_seq_pkg
// Shared definitions for the divide/square-root front-end sequencer:
//   - single-precision field widths (C_OP, C_EXP, C_MANT)
//   - canonical quiet NaN and positive infinity encodings
//   - bit positions of the {NV,DZ,OF,UF,NX} exception flag vector
//   - sequencer FSM state type
//   - operand classification helper used by the special-case logic
// ----------------------------------------------------------------------------
package div_sqrt_seq_pkg;

    localparam int C_OP   = 32;
    localparam int C_EXP  = 8;
    localparam int C_MANT = 23;

    localparam logic [C_OP-1:0] C_QNAN = 32'h7FC0_0000;
    localparam logic [C_OP-1:0] C_PINF = 32'h7F80_0000;

    // Flag vector layout is {NV,DZ,OF,UF,NX}, so NX is the LSB.
    localparam int C_FLAG_NV = 4;
    localparam int C_FLAG_DZ = 3;
    localparam int C_FLAG_OF = 2;
    localparam int C_FLAG_UF = 1;
    localparam int C_FLAG_NX = 0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NORM,
        OUT
    } div_sqrt_seq_state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp_class_t;

    // A zero exponent counts as zero whatever the fraction holds, so
    // denormal operands behave exactly like signed zeros.
    function automatic fp_class_t classify(input logic [C_EXP-1:0]  exp_field,
                                           input logic [C_MANT-1:0] frac_field);
        fp_class_t c;
        c.is_zero = (exp_field == '0);
        c.is_inf  = (exp_field == '1) && (frac_field == '0);
        c.is_nan  = (exp_field == '1) && (frac_field != '0);
        c.is_snan = c.is_nan && !frac_field[C_MANT-1];
        return c;
    endfunction

endpackage

// File: rtl/div_sqrt_seq_special.sv
// ----------------------------------------------------------------------------
// div_sqrt_special
// Combinational classification of the two packed operands and selection of
// the special-case result, so the sequencer can skip the iterative core.
//   operand_a_i  dividend or radicand
//   operand_b_i  divisor (unused for square root)
//   op_div_i     1 = divide, 0 = square root
//   special_o    operation is resolved here without the core
//   result_o     packed special-case result (valid when special_o)
//   flags_o      {NV,DZ,OF,UF,NX} for the special-case result
// ----------------------------------------------------------------------------
module div_sqrt_special
    import div_sqrt_seq_pkg::*;
(
    input  logic [C_OP-1:0] operand_a_i,
    input  logic [C_OP-1:0] operand_b_i,
    input  logic            op_div_i,
    output logic            special_o,
    output logic [C_OP-1:0] result_o,
    output logic [4:0]      flags_o
);

    fp_class_t class_a;
    fp_class_t class_b;
    logic      sign_div;

    assign class_a  = classify(operand_a_i[C_OP-2:C_MANT], operand_a_i[C_MANT-1:0]);
    assign class_b  = classify(operand_b_i[C_OP-2:C_MANT], operand_b_i[C_MANT-1:0]);
    assign sign_div = operand_a_i[C_OP-1] ^ operand_b_i[C_OP-1];

    // Priority chain: NaNs first, then the invalid combinations, then the
    // exact infinity/zero results. Whatever falls through goes to the core.
    always_comb begin
        special_o = 1'b0;
        result_o  = '0;
        flags_o   = '0;
        if (op_div_i) begin
            if (class_a.is_nan || class_b.is_nan) begin
                special_o          = 1'b1;
                result_o           = C_QNAN;
                flags_o[C_FLAG_NV] = class_a.is_snan | class_b.is_snan;
            end else if ((class_a.is_zero && class_b.is_zero) ||
                         (class_a.is_inf  && class_b.is_inf)) begin
                special_o          = 1'b1;
                result_o           = C_QNAN;
                flags_o[C_FLAG_NV] = 1'b1;
            end else if (class_b.is_zero && !class_a.is_inf) begin
                special_o          = 1'b1;
                result_o           = {sign_div, C_PINF[C_OP-2:0]};
                flags_o[C_FLAG_DZ] = 1'b1;
            end else if (class_a.is_inf) begin
                special_o = 1'b1;
                result_o  = {sign_div, C_PINF[C_OP-2:0]};
            end else if (class_b.is_inf || class_a.is_zero) begin
                special_o = 1'b1;
                result_o  = {sign_div, {(C_OP-1){1'b0}}};
            end
        end else begin
            if (class_a.is_nan) begin
                special_o          = 1'b1;
                result_o           = C_QNAN;
                flags_o[C_FLAG_NV] = class_a.is_snan;
            end else if (class_a.is_zero) begin
                special_o = 1'b1;
                result_o  = {operand_a_i[C_OP-1], {(C_OP-1){1'b0}}};
            end else if (operand_a_i[C_OP-1]) begin
                special_o          = 1'b1;
                result_o           = C_QNAN;
                flags_o[C_FLAG_NV] = 1'b1;
            end else if (class_a.is_inf) begin
                special_o = 1'b1;
                result_o  = C_PINF;
            end
        end
    end

endmodule

// File: rtl/div_sqrt_seq.sv
// ----------------------------------------------------------------------------
// div_sqrt_seq
// Front-end sequencer and result packer for the iterative divide/sqrt core.
// Upstream side:   Operand_a_DI, Operand_b_DI, Op_div_SI, Valid_SI / Ready_SO
// Downstream side: Result_DO, Flags_DO {NV,DZ,OF,UF,NX}, Valid_SO / Ready_SI
// Core side:       Core_start_SO (+ div/sqrt select), Core_mant_*/Core_exp_*
//                  operands, Core_ready_SI, Core_done_SI, Core_mant_z_DI and
//                  Core_exp_z_DI pre-normalized result.
// Special cases are answered directly; everything else runs through
// IDLE -> ISSUE -> WAIT -> NORM -> OUT.
// ----------------------------------------------------------------------------
module div_sqrt_seq
    import div_sqrt_seq_pkg::*;
(
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic [C_OP-1:0]   Operand_a_DI,
    input  logic [C_OP-1:0]   Operand_b_DI,
    input  logic              Op_div_SI,
    input  logic              Valid_SI,
    output logic              Ready_SO,
    output logic [C_OP-1:0]   Result_DO,
    output logic [4:0]        Flags_DO,
    output logic              Valid_SO,
    input  logic              Ready_SI,
    output logic              Core_start_SO,
    output logic              Core_div_start_SO,
    output logic              Core_sqrt_start_SO,
    output logic [C_MANT:0]   Core_mant_a_DO,
    output logic [C_MANT:0]   Core_mant_b_DO,
    output logic [C_EXP:0]    Core_exp_a_DO,
    output logic [C_EXP:0]    Core_exp_b_DO,
    input  logic              Core_ready_SI,
    input  logic              Core_done_SI,
    input  logic [C_MANT:0]   Core_mant_z_DI,
    input  logic [C_EXP+1:0]  Core_exp_z_DI
);

    div_sqrt_seq_state_t state_q, state_d;

    logic              op_div_q, op_div_d;
    logic              sign_q,   sign_d;
    logic [C_MANT:0]   mant_a_q, mant_a_d;
    logic [C_MANT:0]   mant_b_q, mant_b_d;
    logic [C_EXP:0]    exp_a_q,  exp_a_d;
    logic [C_EXP:0]    exp_b_q,  exp_b_d;
    logic [C_MANT:0]   mant_z_q, mant_z_d;
    logic [C_EXP+1:0]  exp_z_q,  exp_z_d;
    logic [C_OP-1:0]   result_q, result_d;
    logic [4:0]        flags_q,  flags_d;

    logic              spec_special;
    logic [C_OP-1:0]   spec_result;
    logic [4:0]        spec_flags;

    logic signed [C_EXP+2:0] norm_exp;
    logic [C_MANT:0]         norm_mant;
    logic [C_OP-1:0]         norm_result;
    logic [4:0]              norm_flags;

    // Classification and special-case answers come straight from the live
    // inputs so they can be registered in the same cycle as the accept.
    div_sqrt_special u_special (
        .operand_a_i (Operand_a_DI),
        .operand_b_i (Operand_b_DI),
        .op_div_i    (Op_div_SI),
        .special_o   (spec_special),
        .result_o    (spec_result),
        .flags_o     (spec_flags)
    );

    // Normalize and range-check the captured core result. The core hands
    // back a mantissa that is at most one position short of normalized, so
    // one conditional left shift is enough. The exponent is widened by one
    // bit first so the decrement cannot wrap. Results outside the normal
    // range saturate to infinity or flush to zero.
    always_comb begin
        norm_exp    = {exp_z_q[C_EXP+1], exp_z_q};
        norm_mant   = mant_z_q;
        norm_result = '0;
        norm_flags  = '0;
        if (!mant_z_q[C_MANT]) begin
            norm_mant = {mant_z_q[C_MANT-1:0], 1'b0};
            norm_exp  = norm_exp - 11'sd1;
        end
        if (norm_exp >= 11'sd255) begin
            norm_result           = {sign_q, C_PINF[C_OP-2:0]};
            norm_flags[C_FLAG_OF] = 1'b1;
            norm_flags[C_FLAG_NX] = 1'b1;
        end else if (norm_exp <= 11'sd0) begin
            norm_result           = {sign_q, {(C_OP-1){1'b0}}};
            norm_flags[C_FLAG_UF] = 1'b1;
            norm_flags[C_FLAG_NX] = 1'b1;
        end else begin
            norm_result = {sign_q, norm_exp[C_EXP-1:0], norm_mant[C_MANT-1:0]};
        end
    end

    // Next-state and datapath capture. Every register holds by default;
    // each state only touches what it owns. The core start strobes are
    // raised for the single ISSUE cycle in which the core reports ready,
    // and that same cycle leaves ISSUE, so the pulse can never repeat.
    always_comb begin
        state_d            = state_q;
        op_div_d           = op_div_q;
        sign_d             = sign_q;
        mant_a_d           = mant_a_q;
        mant_b_d           = mant_b_q;
        exp_a_d            = exp_a_q;
        exp_b_d            = exp_b_q;
        mant_z_d           = mant_z_q;
        exp_z_d            = exp_z_q;
        result_d           = result_q;
        flags_d            = flags_q;
        Core_start_SO      = 1'b0;
        Core_div_start_SO  = 1'b0;
        Core_sqrt_start_SO = 1'b0;

        case (state_q)
            IDLE: begin
                if (Valid_SI) begin
                    op_div_d = Op_div_SI;
                    sign_d   = Op_div_SI ? (Operand_a_DI[C_OP-1] ^ Operand_b_DI[C_OP-1])
                                         : Operand_a_DI[C_OP-1];
                    mant_a_d = {1'b1, Operand_a_DI[C_MANT-1:0]};
                    mant_b_d = {1'b1, Operand_b_DI[C_MANT-1:0]};
                    exp_a_d  = {1'b0, Operand_a_DI[C_OP-2:C_MANT]};
                    exp_b_d  = {1'b0, Operand_b_DI[C_OP-2:C_MANT]};
                    if (spec_special) begin
                        result_d = spec_result;
                        flags_d  = spec_flags;
                        state_d  = OUT;
                    end else begin
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (Core_ready_SI) begin
                    Core_start_SO      = 1'b1;
                    Core_div_start_SO  = op_div_q;
                    Core_sqrt_start_SO = !op_div_q;
                    state_d            = WAIT;
                end
            end
            WAIT: begin
                if (Core_done_SI) begin
                    mant_z_d = Core_mant_z_DI;
                    exp_z_d  = Core_exp_z_DI;
                    state_d  = NORM;
                end
            end
            NORM: begin
                result_d = norm_result;
                flags_d  = norm_flags;
                state_d  = OUT;
            end
            OUT: begin
                if (Ready_SI) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any operation in flight
    // and clears every operand and result register.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q  <= IDLE;
            op_div_q <= 1'b0;
            sign_q   <= 1'b0;
            mant_a_q <= '0;
            mant_b_q <= '0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            mant_z_q <= '0;
            exp_z_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_div_q <= op_div_d;
            sign_q   <= sign_d;
            mant_a_q <= mant_a_d;
            mant_b_q <= mant_b_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
            mant_z_q <= mant_z_d;
            exp_z_q  <= exp_z_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Handshake outputs follow the state directly; core operands come from
    // the captured registers so they stay put until the core is done.
    assign Ready_SO       = (state_q == IDLE);
    assign Valid_SO       = (state_q == OUT);
    assign Result_DO      = result_q;
    assign Flags_DO       = flags_q;
    assign Core_mant_a_DO = mant_a_q;
    assign Core_mant_b_DO = mant_b_q;
    assign Core_exp_a_DO  = exp_a_q;
    assign Core_exp_b_DO  = exp_b_q;

endmodule

// File: tb/tb_div_sqrt_seq.sv
// ----------------------------------------------------------------------------
// tb_div_sqrt_seq
// Scoreboard bench for div_sqrt_seq. Stimulus pushes the hand-computed
// expected result into a queue; a monitor pops and compares on each output
// handshake and checks output latency. A small core model answers start
// pulses with programmed mantissa/exponent values.
// ----------------------------------------------------------------------------
module tb_div_sqrt_seq;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;
    localparam logic [4:0]  F_NV = 5'b10000;
    localparam logic [4:0]  F_DZ = 5'b01000;
    localparam logic [4:0]  F_OF = 5'b00100;
    localparam logic [4:0]  F_UF = 5'b00010;
    localparam logic [4:0]  F_NX = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        op_div_si = 1'b0;
    logic        valid_si = 1'b0;
    logic        ready_so;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        valid_so;
    logic        ready_si = 1'b1;
    logic        core_start;
    logic        core_div_start;
    logic        core_sqrt_start;
    logic [23:0] core_mant_a;
    logic [23:0] core_mant_b;
    logic [8:0]  core_exp_a;
    logic [8:0]  core_exp_b;
    logic        core_ready = 1'b1;
    logic        core_done = 1'b0;
    logic [23:0] core_mant_z = '0;
    logic [9:0]  core_exp_z = '0;

    always #5 clk = ~clk;

    div_sqrt_seq dut (
        .Clk_CI             (clk),
        .Rst_RI             (rst),
        .Operand_a_DI       (op_a),
        .Operand_b_DI       (op_b),
        .Op_div_SI          (op_div_si),
        .Valid_SI           (valid_si),
        .Ready_SO           (ready_so),
        .Result_DO          (result),
        .Flags_DO           (flags),
        .Valid_SO           (valid_so),
        .Ready_SI           (ready_si),
        .Core_start_SO      (core_start),
        .Core_div_start_SO  (core_div_start),
        .Core_sqrt_start_SO (core_sqrt_start),
        .Core_mant_a_DO     (core_mant_a),
        .Core_mant_b_DO     (core_mant_b),
        .Core_exp_a_DO      (core_exp_a),
        .Core_exp_b_DO      (core_exp_b),
        .Core_ready_SI      (core_ready),
        .Core_done_SI       (core_done),
        .Core_mant_z_DI     (core_mant_z),
        .Core_exp_z_DI      (core_exp_z)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        bit          special;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int done_cyc = 0;

    // Core model programming and observations
    logic [23:0] cm_mant_z = '0;
    logic [9:0]  cm_exp_z = '0;
    int          cm_delay = 3;
    int          start_count = 0;
    logic        last_div = 1'b0;
    logic        last_sqrt = 1'b0;
    logic [23:0] last_mant_a = '0;
    logic [23:0] last_mant_b = '0;
    logic [8:0]  last_exp_a = '0;
    logic [8:0]  last_exp_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model: sees the start strobe at the falling edge, records the
    // operands it was handed, then answers with a one-cycle done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (core_start) begin
                start_count++;
                last_div    = core_div_start;
                last_sqrt   = core_sqrt_start;
                last_mant_a = core_mant_a;
                last_mant_b = core_mant_b;
                last_exp_a  = core_exp_a;
                last_exp_b  = core_exp_b;
                repeat (cm_delay) @(negedge clk);
                core_mant_z = cm_mant_z;
                core_exp_z  = cm_exp_z;
                core_done   = 1'b1;
                done_cyc    = cyc;
                @(negedge clk);
                core_done   = 1'b0;
            end
        end
    end

    // Monitor: latency check on the rising edge of Valid_SO, result and
    // flag check on each output handshake.
    initial begin
        bit   prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_so && !prev_valid) begin
                if (sb_q.size() == 0)
                    checkOutput("unexpected_valid", {31'b0, valid_so}, 32'h0);
                else if (sb_q[0].special)
                    checkOutput("special_latency", 32'(cyc), 32'(accept_cyc + 1));
                else
                    checkOutput("norm_latency", 32'(cyc), 32'(done_cyc + 2));
            end
            if (valid_so && ready_si && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("flags", {27'b0, flags}, {27'b0, e.flg});
            end
            prev_valid = valid_so;
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic div,
                                 input logic [31:0] exp_res, input logic [4:0] exp_flg,
                                 input bit special);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!ready_so && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_so) begin
            checkOutput("ready_timeout", {31'b0, ready_so}, 32'h1);
            return;
        end
        e.res     = exp_res;
        e.flg     = exp_flg;
        e.special = special;
        sb_q.push_back(e);
        op_a       = a;
        op_b       = b;
        op_div_si  = div;
        valid_si   = 1'b1;
        accept_cyc = cyc;
        @(posedge clk);
        #1 valid_si = 1'b0;
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(sb_q.size() == 0 && ready_so) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("done_timeout", 32'(sb_q.size()), 32'h0);
            sb_q.delete();
        end
    endtask

    task automatic runDiv62(input logic [23:0] mz, input logic [9:0] ez, input logic [31:0] exp_res,
                            input logic [4:0] exp_flg);
        int s0;
        cm_mant_z = mz;
        cm_exp_z  = ez;
        s0        = start_count;
        applyStimulus(32'h40C0_0000, 32'h4000_0000, 1'b1, exp_res, exp_flg, 1'b0);
        waitIdle();
        checkOutput("div_start_count", 32'(start_count - s0), 32'h1);
    endtask

    task automatic runSpecial(input logic [31:0] a, input logic [31:0] b, input logic div,
                              input logic [31:0] exp_res, input logic [4:0] exp_flg);
        int s0;
        s0 = start_count;
        applyStimulus(a, b, div, exp_res, exp_flg, 1'b1);
        waitIdle();
        checkOutput("special_no_start", 32'(start_count - s0), 32'h0);
    endtask

    initial begin
        int s0;
        int waited;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ready_so", {31'b0, ready_so}, 32'h1);
        checkOutput("rst_valid_so", {31'b0, valid_so}, 32'h0);
        checkOutput("rst_result", result, 32'h0);
        checkOutput("rst_flags", {27'b0, flags}, 32'h0);
        checkOutput("rst_core_start", {29'b0, core_start, core_div_start, core_sqrt_start}, 32'h0);
        checkOutput("rst_core_mant_a", {8'b0, core_mant_a}, 32'h0);
        rst = 1'b0;

        // 6.0 / 2.0 = 3.0
        cm_delay = 3;
        runDiv62(24'hC0_0000, 10'd128, 32'h4040_0000, 5'b0);
        checkOutput("div_sel", {31'b0, last_div}, 32'h1);
        checkOutput("div_sqrt_sel", {31'b0, last_sqrt}, 32'h0);
        checkOutput("div_mant_a", {8'b0, last_mant_a}, 32'h00C0_0000);
        checkOutput("div_mant_b", {8'b0, last_mant_b}, 32'h0080_0000);
        checkOutput("div_exp_a", {23'b0, last_exp_a}, 32'd129);
        checkOutput("div_exp_b", {23'b0, last_exp_b}, 32'd128);

        // sqrt(4.0) = 2.0
        cm_mant_z = 24'h80_0000;
        cm_exp_z  = 10'd128;
        s0 = start_count;
        applyStimulus(32'h4080_0000, 32'h0, 1'b0, 32'h4000_0000, 5'b0, 1'b0);
        waitIdle();
        checkOutput("sqrt_start_count", 32'(start_count - s0), 32'h1);
        checkOutput("sqrt_sel", {31'b0, last_sqrt}, 32'h1);
        checkOutput("sqrt_div_sel", {31'b0, last_div}, 32'h0);
        checkOutput("sqrt_exp_a", {23'b0, last_exp_a}, 32'd129);

        // Special cases
        runSpecial(32'h3F80_0000, 32'h0000_0000, 1'b1, PINF, F_DZ);
        runSpecial(32'hBF80_0000, 32'h0, 1'b0, QNAN, F_NV);
        runSpecial(32'h0000_0000, 32'h0000_0000, 1'b1, QNAN, F_NV);
        runSpecial(32'h7FC0_0000, 32'h3F80_0000, 1'b1, QNAN, 5'b0);
        runSpecial(32'h7F80_0001, 32'h0, 1'b0, QNAN, F_NV);
        runSpecial(32'h7F80_0000, 32'h4000_0000, 1'b1, PINF, 5'b0);
        runSpecial(32'hC0C0_0000, 32'h7F80_0000, 1'b1, 32'h8000_0000, 5'b0);
        runSpecial(32'h8000_0000, 32'h0, 1'b0, 32'h8000_0000, 5'b0);

        // Range checks and normalization shift
        runDiv62(24'hC0_0000, 10'd255, PINF, F_OF | F_NX);
        runDiv62(24'hC0_0000, 10'd0, 32'h0000_0000, F_UF | F_NX);
        runDiv62(24'h60_0000, 10'd128, 32'h3FC0_0000, 5'b0);

        // Negative quotient: -6.0 / 2.0 = -3.0
        cm_mant_z = 24'hC0_0000;
        cm_exp_z  = 10'd128;
        applyStimulus(32'hC0C0_0000, 32'h4000_0000, 1'b1, 32'hC040_0000, 5'b0, 1'b0);
        waitIdle();

        // Core not ready for 4 cycles: no start until it is
        core_ready = 1'b0;
        cm_mant_z  = 24'hC0_0000;
        cm_exp_z   = 10'd128;
        s0 = start_count;
        applyStimulus(32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 5'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_no_start", {31'b0, core_start}, 32'h0);
        end
        @(posedge clk);
        #1 core_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_start_pulse", {31'b0, core_start}, 32'h1);
        waitIdle();
        checkOutput("stall_start_count", 32'(start_count - s0), 32'h1);

        // Downstream backpressure for 5 cycles
        ready_si = 1'b0;
        applyStimulus(32'h3F80_0000, 32'h0000_0000, 1'b1, PINF, F_DZ, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_so", {31'b0, valid_so}, 32'h1);
            checkOutput("bp_result", result, PINF);
            checkOutput("bp_flags", {27'b0, flags}, {27'b0, F_DZ});
            checkOutput("bp_ready_so", {31'b0, ready_so}, 32'h0);
        end
        @(posedge clk);
        #1 ready_si = 1'b1;
        waitIdle();

        // Reset in the middle of WAIT; the core's late done must be ignored
        cm_delay = 10;
        s0 = start_count;
        applyStimulus(32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 5'b0, 1'b0);
        waited = 0;
        while (start_count == s0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rst_mid_started", 32'(start_count - s0), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_ready_so", {31'b0, ready_so}, 32'h1);
        checkOutput("rst_mid_valid_so", {31'b0, valid_so}, 32'h0);
        checkOutput("rst_mid_result", result, 32'h0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("late_done_ready_so", {31'b0, ready_so}, 32'h1);
        checkOutput("late_done_valid_so", {31'b0, valid_so}, 32'h0);

        // Fresh operation after the abort
        cm_delay = 3;
        runDiv62(24'hC0_0000, 10'd128, 32'h4040_0000, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
